// File: rtl/debug_pkg.sv
// Shared definitions for the UART debug link: FSM state codes, command byte and frame layout.
package debug_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEND  = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;

  localparam logic [7:0] DBG_CMD_DUMP = 8'h64;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/debug_uart_byte.sv
// 8N1 byte transmitter and receiver sharing one bit period of DIV clocks.
module debug_uart_byte
  import debug_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx,
  input  logic       rx,
  input  logic       rx_en,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [3:0]    TX_LAST   = 4'(UART_FRAME_BITS - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_shift;

  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  logic [1:0]    rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          stop_smp;

  assign tx_done = tx_busy && (tx_cnt == DIV_LAST) && (tx_bit == TX_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_busy <= 1'b0;
      tx      <= 1'b1;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx      <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == DIV_LAST) begin
      tx_cnt <= '0;
      if (tx_done) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx_bit <= tx_bit + 1'b1;
        tx     <= tx_shift[0];
      end
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // tx_shift holds the bits still to go out: data LSB first, then the stop bit.
  always_ff @(posedge clk) begin
    if (!tx_busy && tx_start)
      tx_shift <= {1'b1, tx_data};
    else if (tx_busy && tx_cnt == DIV_LAST)
      tx_shift <= {1'b1, tx_shift[8:1]};
  end

  assign rx_s         = rx_sync[1];
  assign stop_smp     = (rx_st == RX_STOP) && (rx_cnt == DIV_LAST);
  assign rx_valid     = stop_smp && rx_s;
  assign rx_frame_err = stop_smp && !rx_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
      if (!rx_en) begin
        rx_st <= RX_IDLE;
      end else begin
        case (rx_st)
          RX_IDLE: begin
            if (rx_prev && !rx_s) begin
              rx_st  <= RX_START;
              rx_cnt <= '0;
            end
          end
          // A start bit that is high again at half a bit time was a glitch.
          RX_START: begin
            if (rx_cnt == HALF_LAST) begin
              rx_cnt <= '0;
              rx_bit <= '0;
              rx_st  <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_cnt == DIV_LAST) begin
              rx_cnt <= '0;
              rx_bit <= rx_bit + 1'b1;
              if (rx_bit == 3'd7) rx_st <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: begin
            if (rx_cnt == DIV_LAST) rx_st <= RX_IDLE;
            else                    rx_cnt <= rx_cnt + 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_st == RX_DATA && rx_cnt == DIV_LAST) rx_data <= {rx_s, rx_data[7:1]};
  end

endmodule

// File: rtl/debug_host_link.sv
// Host-side initiator of the UART debug dump: sends one command, collects NUM_WORDS words.
// Optional trailing XOR checksum byte when DEBUG_HOST_CHECKSUM_EN is defined.
module debug_host_link
  import debug_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int BAUD         = 19_200,
  parameter int NUM_WORDS    = 32,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        word_valid,
  output logic [4:0]  word_idx,
  output logic [31:0] word_data,
  output logic        done,
  output logic        err
);

  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TMO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TW       = $clog2(TMO_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CLKS - 1);
  localparam logic [4:0]    IDX_LAST = 5'(NUM_WORDS - 1);

  logic [2:0]    state;
  logic          tx_start, tx_busy, tx_done;
  logic          rx_en, rx_valid, rx_frame_err;
  logic [7:0]    rx_data;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [23:0]   asm_bytes;
  logic          check_ok;

`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_RECV = ST_CHECK;
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (tx_start)                        csum <= '0;
    else if (state == ST_RECV && rx_valid) csum <= csum ^ rx_data;
  end
  assign check_ok = (rx_data == csum);
`else
  localparam logic [2:0] ST_AFTER_RECV = ST_DONE;
  assign check_ok = 1'b0;
`endif

  assign tx_start = (state == ST_IDLE) && start && !tx_busy;
  assign rx_en    = (state == ST_RECV) || (state == ST_CHECK);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ABORT);

  debug_uart_byte #(.DIV(DIV)) u_uart (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_start     (tx_start),
    .tx_data      (cmd),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx           (tx),
    .rx           (rx),
    .rx_en        (rx_en),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      word_valid <= 1'b0;
      word_idx   <= '0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (word_valid && word_idx != IDX_LAST) word_idx <= word_idx + 1'b1;
      case (state)
        ST_IDLE: if (tx_start) state <= ST_SEND;
        ST_SEND: begin
          if (tx_done) begin
            state    <= ST_RECV;
            tmo_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        // The gap timer restarts at every good stop bit and runs until the next one.
        ST_RECV, ST_CHECK: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (rx_frame_err || tmo_cnt == TMO_LAST) begin
            state <= ST_ABORT;
          end else if (rx_valid) begin
            tmo_cnt <= '0;
            if (state == ST_CHECK) begin
              state <= check_ok ? ST_DONE : ST_ABORT;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              if (byte_cnt == 2'd3) begin
                word_valid <= 1'b1;
                word_data  <= {rx_data, asm_bytes};
                if (word_idx == IDX_LAST) state <= ST_AFTER_RECV;
              end
            end
          end
        end
        ST_DONE, ST_ABORT: begin
          state    <= ST_IDLE;
          word_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // First three bytes of a word, oldest in the low byte.
  always_ff @(posedge clk) begin
    if (state == ST_RECV && rx_valid) asm_bytes <= {rx_data, asm_bytes[23:8]};
  end

endmodule

// File: tb/tb_debug_host_link.sv
// Bench for debug_host_link: acts as the UART responder, compares strobes against a word-level model.
module tb_debug_host_link;
  import debug_pkg::*;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int NW       = 32;
  localparam int TMO_BITS = 64;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TMO_CLKS = TMO_BITS * DIV;
`ifdef DEBUG_HOST_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, start, rx;
  logic [7:0]  cmd;
  logic        tx, busy, word_valid, done, err;
  logic [4:0]  word_idx;
  logic [31:0] word_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [4:0]  got_idx[$];
  logic [31:0] got_data[$];
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, pulse_cyc = 0;

  debug_host_link #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_WORDS(NW), .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd(cmd), .rx(rx), .tx(tx),
    .busy(busy), .word_valid(word_valid), .word_idx(word_idx), .word_data(word_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (word_valid) begin
        got_idx.push_back(word_idx);
        got_data.push_back(word_data);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (done && err) both_cnt <= both_cnt + 1;
      if (done || err) pulse_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic uart_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(DIV);
    end
    rx = stop_bit;
    wait_clks(DIV);
    rx = 1'b1;
  endtask

  // Issues a command and checks its serial frame bit by bit at mid-bit.
  task automatic send_cmd(input logic [7:0] c);
    logic [9:0] frame;
    frame = {1'b1, c, 1'b0};
    @(negedge clk);
    chk("busy_before_start", 32'(busy), 0);
    start = 1'b1;
    cmd   = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    cmd   = 8'($urandom);
    chk("busy_rise", 32'(busy), 1);
    wait_clks(DIV / 2 - 1);
    for (int b = 0; b < 10; b++) begin
      chk($sformatf("tx_bit%0d", b), 32'(tx), 32'(frame[b]));
      wait_clks(DIV);
    end
  endtask

  task automatic do_dump(input bit fixed, input int fe_at, input int stop_after,
                         input bit bad_sum, input bit extras);
    logic [31:0] words[NW];
    logic [7:0]  sum, b;
    int nbytes, exp_words, base_w, base_d, base_e, base_b, t_end, budget, diff;
    bit exp_err;
    sum = 8'h00;
    for (int k = 0; k < NW; k++) begin
      words[k] = fixed ? 32'h1000_0000 + 32'(k) : $urandom;
      for (int j = 0; j < 4; j++) sum ^= words[k][8*j +: 8];
    end
    nbytes    = 4 * NW + CSUM_BYTES;
    exp_err   = (fe_at >= 0) || (stop_after >= 0) || (CSUM_BYTES != 0 && bad_sum);
    exp_words = (fe_at >= 0) ? fe_at / 4 : (stop_after >= 0) ? stop_after / 4 : NW;
    base_w = got_idx.size();
    base_d = done_cnt;
    base_e = err_cnt;
    base_b = both_cnt;
    t_end  = cyc;

    send_cmd(DBG_CMD_DUMP);
    wait_clks(4);
    for (int i = 0; i < nbytes; i++) begin
      if (i == stop_after) break;
      if (i < 4 * NW) b = words[i/4][8*(i%4) +: 8];
      else            b = sum ^ {7'd0, bad_sum};
      uart_byte(b, i != fe_at);
      t_end = cyc;
      if (i == fe_at) break;
      if (extras && i == 10) begin
        rx = 1'b0;
        wait_clks(3);
        rx = 1'b1;
        wait_clks(2 * DIV);
      end
      if (extras && i == 20) begin
        @(negedge clk);
        start = 1'b1;
        cmd   = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        wait_clks(DIV / 2);
        chk("tx_quiet_start_while_busy", 32'(tx), 1);
      end
      wait_clks($urandom_range(0, 2 * DIV));
    end

    budget = TMO_CLKS + 20 * DIV;
    while (done_cnt + err_cnt == base_d + base_e && budget > 0) begin
      wait_clks(1);
      budget--;
    end
    chk("outcome_within_budget", 32'(budget > 0), 1);
    if (stop_after >= 0) begin
      diff = pulse_cyc - t_end;
      chk("timeout_latency_near_640", 32'(diff >= TMO_CLKS - DIV && diff <= TMO_CLKS + DIV), 1);
    end
    wait_clks(3);
    chk("done_pulses", 32'(done_cnt - base_d), exp_err ? 0 : 1);
    chk("err_pulses", 32'(err_cnt - base_e), exp_err ? 1 : 0);
    chk("word_strobes", 32'(got_idx.size() - base_w), 32'(exp_words));
    for (int k = 0; k < exp_words && base_w + k < got_idx.size(); k++) begin
      chk($sformatf("word_idx_%0d", k), 32'(got_idx[base_w + k]), 32'(k));
      chk($sformatf("word_data_%0d", k), got_data[base_w + k], words[k]);
    end
    chk("busy_fell", 32'(busy), 0);
    chk("word_idx_wrapped", 32'(word_idx), 0);
    chk("tx_idle_high", 32'(tx), 1);
    chk("done_err_exclusive", 32'(both_cnt - base_b), 0);
  endtask

  task automatic reset_mid_recv();
    int base_d, base_e;
    base_d = done_cnt;
    base_e = err_cnt;
    send_cmd(DBG_CMD_DUMP);
    wait_clks(4);
    for (int i = 0; i < 6; i++) uart_byte(8'($urandom), 1'b1);
    rx = 1'b0;
    wait_clks(3 * DIV);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_word_idx", 32'(word_idx), 0);
    chk("rst_word_data", word_data, 0);
    rx = 1'b1;
    wait_clks(3);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clks(TMO_CLKS + 50);
    chk("no_pulse_after_reset", 32'((done_cnt - base_d) + (err_cnt - base_e)), 0);
    chk("idle_after_reset", 32'(busy), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    cmd     = 8'h00;
    rx      = 1'b1;
    wait_clks(3);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_word_valid", 32'(word_valid), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_word_idx", 32'(word_idx), 0);
    chk("reset_word_data", word_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_clks(5);

    do_dump(1'b1, -1, -1, 1'b0, 1'b1);
    do_dump(1'b0, -1, -1, 1'b0, 1'b0);
    do_dump(1'b0, 4, -1, 1'b0, 1'b0);
    do_dump(1'b0, -1, 40, 1'b0, 1'b0);
    reset_mid_recv();
`ifdef DEBUG_HOST_CHECKSUM_EN
    do_dump(1'b0, -1, -1, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
